// File: rtl/cursor_ctrl.sv
// Grid cursor driven by a 5-bit button code, with hold-to-repeat and
// either wrapping or saturating edges.
`ifndef BUTTON_NONE
`define BUTTON_NONE  5'd0
`endif
`ifndef BUTTON_UP
`define BUTTON_UP    5'd1
`endif
`ifndef BUTTON_DOWN
`define BUTTON_DOWN  5'd2
`endif
`ifndef BUTTON_LEFT
`define BUTTON_LEFT  5'd3
`endif
`ifndef BUTTON_RIGHT
`define BUTTON_RIGHT 5'd4
`endif

module cursor_ctrl #(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int X_INIT       = 0,
  parameter int Y_INIT       = 0,
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    button_i,
  output logic [XW-1:0] x_pos_o,
  output logic [YW-1:0] y_pos_o,
  output logic [PW-1:0] position_o,
  output logic          moved_o,
  output logic          blocked_o
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    btn_q;

  logic          is_dir, press, held;
  logic          delay_done, rate_done, do_move;
  logic          at_edge;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;

  always_comb begin
    is_dir     = (button_i == `BUTTON_UP)   || (button_i == `BUTTON_DOWN) ||
                 (button_i == `BUTTON_LEFT) || (button_i == `BUTTON_RIGHT);
    press      = is_dir && (button_i != btn_q);
    held       = is_dir && (button_i == btn_q);
    delay_done = (REPEAT_DELAY > 0) && (cnt == CW'(REPEAT_DELAY - 1));
    rate_done  = (cnt == CW'(REPEAT_RATE - 1));
    do_move    = press || (held && (((state == DELAY) && delay_done) ||
                                    ((state == REPEAT) && rate_done)));
  end

  // Candidate coordinates for the current button; at_edge flags a saturated move.
  always_comb begin
    x_next  = x_pos_o;
    y_next  = y_pos_o;
    at_edge = 1'b0;
    case (button_i)
      `BUTTON_UP: begin
        if (y_pos_o == '0) begin
          if (WRAP != 0) y_next = YW'(ROWS - 1);
          else           at_edge = 1'b1;
        end else begin
          y_next = y_pos_o - YW'(1);
        end
      end
      `BUTTON_DOWN: begin
        if (y_pos_o == YW'(ROWS - 1)) begin
          if (WRAP != 0) y_next = '0;
          else           at_edge = 1'b1;
        end else begin
          y_next = y_pos_o + YW'(1);
        end
      end
      `BUTTON_LEFT: begin
        if (x_pos_o == '0) begin
          if (WRAP != 0) x_next = XW'(COLS - 1);
          else           at_edge = 1'b1;
        end else begin
          x_next = x_pos_o - XW'(1);
        end
      end
      `BUTTON_RIGHT: begin
        if (x_pos_o == XW'(COLS - 1)) begin
          if (WRAP != 0) x_next = '0;
          else           at_edge = 1'b1;
        end else begin
          x_next = x_pos_o + XW'(1);
        end
      end
      default: begin
        x_next  = x_pos_o;
        y_next  = y_pos_o;
        at_edge = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      btn_q      <= `BUTTON_NONE;
      x_pos_o    <= XW'(X_INIT);
      y_pos_o    <= YW'(Y_INIT);
      position_o <= PW'(Y_INIT * COLS + X_INIT);
      moved_o    <= 1'b0;
      blocked_o  <= 1'b0;
    end else begin
      btn_q     <= button_i;
      moved_o   <= 1'b0;
      blocked_o <= 1'b0;

      if (do_move) begin
        if (at_edge) begin
          blocked_o <= 1'b1;
        end else begin
          x_pos_o    <= x_next;
          y_pos_o    <= y_next;
          position_o <= PW'(int'(y_next) * COLS + int'(x_next));
          moved_o    <= 1'b1;
        end
      end

      // The counter restarts from zero on every state entry, including a DELAY re-entry.
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press && (REPEAT_DELAY > 0)) state <= DELAY;
        end
        DELAY: begin
          if (press) begin
            cnt <= '0;
          end else if (!is_dir) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (delay_done) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPEAT: begin
          if (press) begin
            state <= (REPEAT_DELAY > 0) ? DELAY : IDLE;
            cnt   <= '0;
          end else if (!is_dir) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rate_done) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: an 8x8 saturating instance and a 5x3 wrapping instance,
// checked with directed tables, hand sequences and a random run against a model.
`ifndef BUTTON_NONE
`define BUTTON_NONE  5'd0
`endif
`ifndef BUTTON_UP
`define BUTTON_UP    5'd1
`endif
`ifndef BUTTON_DOWN
`define BUTTON_DOWN  5'd2
`endif
`ifndef BUTTON_LEFT
`define BUTTON_LEFT  5'd3
`endif
`ifndef BUTTON_RIGHT
`define BUTTON_RIGHT 5'd4
`endif

module tb_cursor_ctrl;

  localparam int RD = 4;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_a, btn_b;

  logic [2:0] xa, ya;
  logic [5:0] pa;
  logic       mva, bla;
  logic [2:0] xb;
  logic [1:0] yb;
  logic [3:0] pb;
  logic       mvb, blb;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cursor_ctrl #(.COLS(8), .ROWS(8), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                .X_INIT(0), .Y_INIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .button_i(btn_a), .x_pos_o(xa), .y_pos_o(ya),
    .position_o(pa), .moved_o(mva), .blocked_o(bla));

  cursor_ctrl #(.COLS(5), .ROWS(3), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                .X_INIT(0), .Y_INIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .button_i(btn_b), .x_pos_o(xb), .y_pos_o(yb),
    .position_o(pb), .moved_o(mvb), .blocked_o(blb));

  typedef struct {
    int x, y;
    logic [4:0] prev;
    int age;
    bit moved, blocked;
  } model_t;

  typedef struct {
    int sel;
    logic [4:0] btn;
    int ex, ey, ep;
    bit em, eb;
  } vec_t;

  model_t ma, mb;
  vec_t   tbl [21];

  function automatic model_t model_init();
    model_t m;
    m.x = 0; m.y = 0; m.prev = `BUTTON_NONE; m.age = 0; m.moved = 0; m.blocked = 0;
    return m;
  endfunction

  // A move fires at the press and then at RD, RD+RR, RD+2*RR, ... held edges after it.
  function automatic model_t model_step(model_t s, logic [4:0] b, int cols, int rows, int wrap);
    model_t n;
    bit dir, fire;
    int dx, dy, nx, ny;
    n = s; n.moved = 0; n.blocked = 0; fire = 0; dx = 0; dy = 0;
    dir = (b == `BUTTON_UP) || (b == `BUTTON_DOWN) || (b == `BUTTON_LEFT) || (b == `BUTTON_RIGHT);
    if (!dir) n.age = 0;
    else if (b != s.prev) begin n.age = 0; fire = 1; end
    else begin
      n.age = s.age + 1;
      fire = (RD > 0) && (n.age >= RD) && (((n.age - RD) % RR) == 0);
    end
    if (fire) begin
      if (b == `BUTTON_UP) dy = -1;
      if (b == `BUTTON_DOWN) dy = 1;
      if (b == `BUTTON_LEFT) dx = -1;
      if (b == `BUTTON_RIGHT) dx = 1;
      nx = s.x + dx; ny = s.y + dy;
      if (wrap != 0) begin
        n.x = (nx + cols) % cols; n.y = (ny + rows) % rows; n.moved = 1;
      end else if (nx < 0 || nx >= cols || ny < 0 || ny >= rows) begin
        n.blocked = 1;
      end else begin
        n.x = nx; n.y = ny; n.moved = 1;
      end
    end
    n.prev = b;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int sel, input int ex, input int ey,
                             input int ep, input bit em, input bit eb);
    int gx, gy, gp;
    bit gm, gb;
    gx = sel ? int'(xb) : int'(xa);
    gy = sel ? int'(yb) : int'(ya);
    gp = sel ? int'(pb) : int'(pa);
    gm = sel ? mvb : mva;
    gb = sel ? blb : bla;
    vec_cnt++;
    if (gx != ex || gy != ey || gp != ep || gm != em || gb != eb) begin
      err_cnt++;
      $display("[TB] FAIL %s (dut %0d): got x=%0d y=%0d pos=%0d moved=%0d blocked=%0d, expected x=%0d y=%0d pos=%0d moved=%0d blocked=%0d",
               name, sel, gx, gy, gp, gm, gb, ex, ey, ep, em, eb);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    btn_a = a;
    btn_b = b;
    @(posedge clk);
    #1;
    ma = model_step(ma, a, 8, 8, 0);
    mb = model_step(mb, b, 5, 3, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_a = `BUTTON_NONE;
    btn_b = `BUTTON_NONE;
    #1;
    checkOutput("reset_state", 0, 0, 0, 0, 0, 0);
    checkOutput("reset_state", 1, 0, 0, 0, 0, 0);
    ma = model_init();
    mb = model_init();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pickButton();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return `BUTTON_NONE;
      1: return `BUTTON_UP;
      2: return `BUTTON_DOWN;
      3: return `BUTTON_LEFT;
      4: return `BUTTON_RIGHT;
      default: return 5'($urandom_range(5, 31));
    endcase
  endfunction

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] cur_a, cur_b;
    int ex;
    bit mv;

    rst_n = 1'b0;
    btn_a = `BUTTON_NONE;
    btn_b = `BUTTON_NONE;
    ma = model_init();
    mb = model_init();

    tbl[0]  = '{0, `BUTTON_DOWN,  0, 1, 8, 1, 0};
    tbl[1]  = '{0, `BUTTON_NONE,  0, 1, 8, 0, 0};
    tbl[2]  = '{0, `BUTTON_RIGHT, 1, 1, 9, 1, 0};
    tbl[3]  = '{0, `BUTTON_NONE,  1, 1, 9, 0, 0};
    tbl[4]  = '{0, `BUTTON_UP,    1, 0, 1, 1, 0};
    tbl[5]  = '{0, 5'd9,          1, 0, 1, 0, 0};
    tbl[6]  = '{0, `BUTTON_LEFT,  0, 0, 0, 1, 0};
    tbl[7]  = '{0, `BUTTON_NONE,  0, 0, 0, 0, 0};
    tbl[8]  = '{0, `BUTTON_UP,    0, 0, 0, 0, 1};
    tbl[9]  = '{0, `BUTTON_NONE,  0, 0, 0, 0, 0};
    tbl[10] = '{0, `BUTTON_LEFT,  0, 0, 0, 0, 1};
    tbl[11] = '{0, `BUTTON_UP,    0, 0, 0, 0, 1};
    tbl[12] = '{0, `BUTTON_NONE,  0, 0, 0, 0, 0};
    tbl[13] = '{1, `BUTTON_LEFT,  4, 0, 4, 1, 0};
    tbl[14] = '{1, `BUTTON_NONE,  4, 0, 4, 0, 0};
    tbl[15] = '{1, `BUTTON_UP,    4, 2, 14, 1, 0};
    tbl[16] = '{1, `BUTTON_NONE,  4, 2, 14, 0, 0};
    tbl[17] = '{1, `BUTTON_RIGHT, 0, 2, 10, 1, 0};
    tbl[18] = '{1, `BUTTON_NONE,  0, 2, 10, 0, 0};
    tbl[19] = '{1, `BUTTON_DOWN,  0, 0, 0, 1, 0};
    tbl[20] = '{1, `BUTTON_NONE,  0, 0, 0, 0, 0};

    doReset();
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].sel == 0) applyStimulus(tbl[i].btn, `BUTTON_NONE);
      else                 applyStimulus(`BUTTON_NONE, tbl[i].btn);
      checkOutput($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].ex, tbl[i].ey,
                  tbl[i].ep, tbl[i].em, tbl[i].eb);
    end

    // Hold RIGHT for 12 edges: moves on edges 0, 4, 6, 8 and 10.
    doReset();
    ex = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(`BUTTON_RIGHT, `BUTTON_NONE);
      mv = (i == 0) || (i == 4) || (i == 6) || (i == 8) || (i == 10);
      if (mv) ex++;
      checkOutput($sformatf("hold_right[%0d]", i), 0, ex, 0, ex, mv, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(`BUTTON_NONE, `BUTTON_NONE);
      checkOutput("release_right", 0, 5, 0, 5, 0, 0);
    end

    // DOWN for three edges, then straight to RIGHT restarts the delay.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(`BUTTON_DOWN, `BUTTON_NONE);
      checkOutput("down_then_switch", 0, 0, 1, 8, i == 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(`BUTTON_RIGHT, `BUTTON_NONE);
      ex = (i < 4) ? 1 : 2;
      checkOutput($sformatf("switch_right[%0d]", i), 0, ex, 1, 8 + ex, (i == 0) || (i == 4), 0);
    end

    // Reset in the middle of a DOWN repeat, button still held across release.
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(`BUTTON_DOWN, `BUTTON_NONE);
    checkOutput("down_repeat", 0, 0, 3, 24, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("press_after_reset", 0, 0, 1, 8, 1, 0);
    ma = model_step(model_init(), `BUTTON_DOWN, 8, 8, 0);
    mb = model_init();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(`BUTTON_DOWN, `BUTTON_NONE);
      checkOutput("held_after_reset", 0, 0, 1, 8, 0, 0);
    end

    // Random run against the behavioural model.
    doReset();
    cur_a = `BUTTON_NONE;
    cur_b = `BUTTON_NONE;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        doReset();
        cur_a = `BUTTON_NONE;
        cur_b = `BUTTON_NONE;
      end
      if ($urandom_range(99) >= 80) cur_a = pickButton();
      if ($urandom_range(99) >= 80) cur_b = pickButton();
      applyStimulus(cur_a, cur_b);
      checkOutput("random_a", 0, ma.x, ma.y, ma.y * 8 + ma.x, ma.moved, ma.blocked);
      checkOutput("random_b", 1, mb.x, mb.y, mb.y * 5 + mb.x, mb.moved, mb.blocked);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
